// File: rtl/pipeline_flush_controller.sv
// pipeline_flush_controller: sequences PC/nPC/IF-ID enables, delay-slot annul and ID/EX bubbles for the SPARC front end.
// Define ANNUL_STATS_EN to build the saturating annul_count statistics counter.
module pipeline_flush_controller #(
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        system_reset,
  input  logic        ID_branch_instr,
  input  logic        ID_branch_taken,
  input  logic        ID_branch_always,
  input  logic        a,
  input  logic        load_use_hazard,
  input  logic        ext_stall,
  output logic        pc_enable,
  output logic        npc_enable,
  output logic        if_id_enable,
  output logic        if_id_reset,
  output logic        id_ex_bubble,
  output logic        pipe_reset,
  output logic        stall_timeout,
  output logic [1:0]  ctrl_state,
  output logic [15:0] annul_count
);
  typedef enum logic [1:0] {INIT = 2'b00, RUN = 2'b01, HOLD = 2'b10} state_t;
  state_t state;
  logic [7:0] hold_cnt, stall_cnt, stall_inc;
  logic annul_pending, annul_req, run, adv;
  assign annul_req = ID_branch_instr & a & (ID_branch_always | ~ID_branch_taken);
  assign stall_inc = stall_cnt == 8'hff ? 8'hff : stall_cnt + 8'd1;
  assign run = state == RUN;
  assign adv = run & ~ext_stall & ~load_use_hazard;
  always_comb begin
    pc_enable = adv;
    npc_enable = adv;
    if_id_enable = adv;
    id_ex_bubble = run & ~ext_stall & load_use_hazard;
    if_id_reset = adv & (annul_req | annul_pending);
    pipe_reset = state == INIT;
    ctrl_state = state;
  end
  always_ff @(posedge clk) begin
    if (system_reset) begin
      state <= INIT;
      hold_cnt <= 8'(RESET_HOLD_CYCLES);
      annul_pending <= 1'b0;
      stall_cnt <= 8'd0;
      stall_timeout <= 1'b0;
    end else begin
      if (state != INIT) begin
        stall_cnt <= ext_stall ? stall_inc : 8'd0;
        if (ext_stall && stall_inc == 8'(STALL_TIMEOUT)) stall_timeout <= 1'b1;
      end
      case (state)
        INIT: begin
          hold_cnt <= hold_cnt - 8'd1;
          if (hold_cnt <= 8'd1) state <= RUN;
        end
        RUN: begin
          // a hazard keeps the branch in ID, so a deferred annul waits for the advancing cycle
          if (ext_stall) begin
            state <= HOLD;
            annul_pending <= annul_pending | annul_req;
          end else if (!load_use_hazard) annul_pending <= 1'b0;
        end
        HOLD: begin
          annul_pending <= annul_pending | annul_req;
          if (!ext_stall) state <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end
`ifdef ANNUL_STATS_EN
  logic [15:0] stat_cnt;
  always_ff @(posedge clk) begin
    if (system_reset) stat_cnt <= 16'd0;
    else if (if_id_reset && stat_cnt != 16'hffff) stat_cnt <= stat_cnt + 16'd1;
  end
  assign annul_count = stat_cnt;
`else
  assign annul_count = 16'h0000;
`endif
endmodule

// File: tb/tb_pipeline_flush_controller.sv
// tb_pipeline_flush_controller: table vectors, corner sequences and randomized checks against a cycle model.
module tb_pipeline_flush_controller;
  localparam int HC = 4;
  localparam int TO = 64;
  localparam logic [6:0] RST = 7'b1000000;
  localparam logic [6:0] ANN = 7'b0100100;
  localparam logic [6:0] TKN = 7'b0110100;
  localparam logic [6:0] BA  = 7'b0111100;
  localparam logic [6:0] NOA = 7'b0100000;
  localparam logic [6:0] LU  = 7'b0000010;
  localparam logic [6:0] ES  = 7'b0000001;
  localparam logic [6:0] IDL = 7'b0000000;
  typedef struct packed {
    logic [6:0] in;
    logic pr, en, ifr, bub;
    logic [1:0] st;
  } vec_t;
  logic clk = 0;
  logic system_reset = 0, ID_branch_instr = 0, ID_branch_taken = 0, ID_branch_always = 0;
  logic a = 0, load_use_hazard = 0, ext_stall = 0;
  logic pc_enable, npc_enable, if_id_enable, if_id_reset, id_ex_bubble, pipe_reset, stall_timeout;
  logic [1:0] ctrl_state;
  logic [15:0] annul_count;
  int checks = 0, errors = 0;
  int m_init = 0, m_run = 0, m_cnt = 0;
  bit m_hold = 0, m_pend = 0, m_to = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  pipeline_flush_controller #(.RESET_HOLD_CYCLES(HC), .STALL_TIMEOUT(TO)) dut (
    .clk(clk), .system_reset(system_reset), .ID_branch_instr(ID_branch_instr),
    .ID_branch_taken(ID_branch_taken), .ID_branch_always(ID_branch_always), .a(a),
    .load_use_hazard(load_use_hazard), .ext_stall(ext_stall), .pc_enable(pc_enable),
    .npc_enable(npc_enable), .if_id_enable(if_id_enable), .if_id_reset(if_id_reset),
    .id_ex_bubble(id_ex_bubble), .pipe_reset(pipe_reset), .stall_timeout(stall_timeout),
    .ctrl_state(ctrl_state), .annul_count(annul_count)
  );
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit areq();
    return ID_branch_instr && a && (ID_branch_always || !ID_branch_taken);
  endfunction
  function automatic bit m_adv();
    return m_init == 0 && !m_hold && !ext_stall && !load_use_hazard;
  endfunction
  function automatic bit m_ifr();
    return m_adv() && (areq() || m_pend);
  endfunction
  function automatic logic [15:0] m_stat();
`ifdef ANNUL_STATS_EN
    return 16'(m_cnt);
`else
    return 16'h0000;
`endif
  endfunction
  task automatic model_check();
    bit run;
    run = m_init == 0 && !m_hold;
    chk("pc_enable", 16'(pc_enable), 16'(m_adv()));
    chk("npc_enable", 16'(npc_enable), 16'(m_adv()));
    chk("if_id_enable", 16'(if_id_enable), 16'(m_adv()));
    chk("if_id_reset", 16'(if_id_reset), 16'(m_ifr()));
    chk("id_ex_bubble", 16'(id_ex_bubble), 16'(run && !ext_stall && load_use_hazard));
    chk("pipe_reset", 16'(pipe_reset), 16'(m_init > 0));
    chk("stall_timeout", 16'(stall_timeout), 16'(m_to));
    chk("ctrl_state", 16'(ctrl_state), m_init > 0 ? 16'd0 : m_hold ? 16'd2 : 16'd1);
    chk("annul_count", annul_count, m_stat());
  endtask
  task automatic model_step();
    if (system_reset) begin
      m_init = HC; m_hold = 0; m_pend = 0; m_run = 0; m_to = 0; m_cnt = 0;
    end else if (m_init > 0) m_init--;
    else begin
      if (m_ifr() && m_cnt < 65535) m_cnt++;
      m_run = ext_stall ? m_run + 1 : 0;
      if (m_run >= TO) m_to = 1;
      if (m_hold || ext_stall) m_pend = m_pend | areq();
      else if (!load_use_hazard) m_pend = 0;
      m_hold = ext_stall;
    end
  endtask
  task automatic set(input logic [6:0] v, input bit check);
    {system_reset, ID_branch_instr, ID_branch_taken, ID_branch_always, a, load_use_hazard, ext_stall} = v;
    #3;
    if (check) model_check();
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  initial begin
    tbl.push_back({ANN | ES, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    for (int i = 0; i < 3; i++) tbl.push_back({IDL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    tbl.push_back({IDL, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
    tbl.push_back({ANN, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1});
    tbl.push_back({IDL, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
    tbl.push_back({TKN, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
    tbl.push_back({BA, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1});
    tbl.push_back({NOA, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
    tbl.push_back({ANN | LU, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
    tbl.push_back({ANN, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1});
    tbl.push_back({ANN | ES, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1});
    tbl.push_back({ES, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2});
    tbl.push_back({ES, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2});
    tbl.push_back({IDL, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2});
    tbl.push_back({IDL, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1});
    tbl.push_back({IDL, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
    tbl.push_back({ANN | ES, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1});
    tbl.push_back({IDL, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2});
    tbl.push_back({LU, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
    tbl.push_back({IDL, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1});
    tbl.push_back({IDL, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
    tbl.push_back({ANN | ES, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1});
    tbl.push_back({RST | ES, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2});
    for (int i = 0; i < 4; i++) tbl.push_back({IDL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    tbl.push_back({IDL, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
    tbl.push_back({ANN, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1});
    tbl.push_back({IDL, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
    tbl.push_back({BA, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1});
    tbl.push_back({ANN, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1});
    set(RST, 0);
    tick();
    foreach (tbl[i]) begin
      set(tbl[i].in, 0);
      chk($sformatf("vec%0d pipe_reset", i), 16'(pipe_reset), 16'(tbl[i].pr));
      chk($sformatf("vec%0d enables", i), 16'({pc_enable, npc_enable, if_id_enable}), {13'd0, {3{tbl[i].en}}});
      chk($sformatf("vec%0d if_id_reset", i), 16'(if_id_reset), 16'(tbl[i].ifr));
      chk($sformatf("vec%0d id_ex_bubble", i), 16'(id_ex_bubble), 16'(tbl[i].bub));
      chk($sformatf("vec%0d ctrl_state", i), 16'(ctrl_state), 16'(tbl[i].st));
      chk($sformatf("vec%0d stall_timeout", i), 16'(stall_timeout), 16'd0);
      tick();
    end
    set(IDL, 1);
`ifdef ANNUL_STATS_EN
    chk("annul_count_three", annul_count, 16'd3);
`else
    chk("annul_count_tied", annul_count, 16'd0);
`endif
    tick();
    for (int i = 0; i < TO; i++) begin
      set(ES, 1);
      if (i == TO - 1) chk("timeout_early", 16'(stall_timeout), 16'd0);
      tick();
    end
    set(IDL, 1);
    chk("timeout_set", 16'(stall_timeout), 16'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set(IDL, 1);
      tick();
    end
    chk("timeout_sticky", 16'(stall_timeout), 16'd1);
    set(ANN | ES, 1);
    tick();
    set(RST | ES, 1);
    tick();
    set(IDL, 1);
    chk("rst_hold_state", 16'(ctrl_state), 16'd0);
    chk("rst_hold_timeout", 16'(stall_timeout), 16'd0);
    for (int i = 0; i < HC; i++) tick();
    set(IDL, 1);
    chk("rst_hold_no_annul", 16'(if_id_reset), 16'd0);
    tick();
    begin
      int es_left = 0;
      logic [6:0] v;
      for (int n = 0; n < 3000; n++) begin
        v = 7'($urandom);
        v[6] = $urandom_range(0, 99) == 0;
        if (es_left == 0 && $urandom_range(0, 5) == 0) es_left = $urandom_range(1, 8);
        v[0] = es_left > 0;
        if (es_left > 0) es_left--;
        v[1] = $urandom_range(0, 3) == 0;
        set(v, 1);
        tick();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_flush_controller.md
Name: pipeline_flush_controller

Overview:
- Sequences the SPARC pipeline-register controls: post-reset hold, load-use stalls, memory-wait freezes and delay-slot annulment.
- Sits beside the hazard unit and drives the enable and synchronous-clear inputs of the PC, nPC and IF/ID registers, plus the bubble select of ID/EX.
- Applies the annul-bit (I29) semantics and defers an annul that arrives during a freeze until the pipeline actually advances.

Parameters:
- RESET_HOLD_CYCLES, 4: cycles pipe_reset stays high after system_reset deasserts; valid range 1..255.
- STALL_TIMEOUT, 64: consecutive ext_stall cycles after which stall_timeout sets; valid range 1..255.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- system_reset  input  1  synchronous, active-high reset.
- ID_branch_instr  input  1  the instruction in ID is a Bicc/branch.
- ID_branch_taken  input  1  branch condition evaluated true this cycle.
- ID_branch_always  input  1  branch is BA (unconditional).
- a  input  1  annul bit (I29) of the branch in ID.
- load_use_hazard  input  1  the hazard unit requests a one-cycle ID stall.
- ext_stall  input  1  memory wait; the whole front end must freeze.
- pc_enable  output  1  PC register load enable.
- npc_enable  output  1  nPC register load enable.
- if_id_enable  output  1  IF/ID register load enable.
- if_id_reset  output  1  synchronous clear of IF/ID (squashes the delay slot).
- id_ex_bubble  output  1  select NOP into ID/EX.
- pipe_reset  output  1  global pipeline-register reset.
- stall_timeout  output  1  sticky watchdog flag.
- ctrl_state  output  2  current state: 00 INIT, 01 RUN, 10 HOLD.
- annul_count  output  16  annul statistics (see Optional Feature).

Behaviour:
- Definition: annul_req = ID_branch_instr & a & (ID_branch_always | ~ID_branch_taken).
- Reset values (cycle after system_reset is sampled high):
  - state INIT, hold counter = RESET_HOLD_CYCLES, annul_pending 0, stall counter 0.
  - stall_timeout 0, annul_count 0.
  - Outputs: pipe_reset 1, all enables 0, if_id_reset 0, id_ex_bubble 0.
- system_reset has priority over every other input in every state, including mid-HOLD; it discards any pending annul.
- INIT:
  - pipe_reset=1, enables=0. The hold counter decrements each cycle.
  - Leave to RUN on the cycle the counter is 1, so pipe_reset stays high for exactly RESET_HOLD_CYCLES cycles after reset deasserts.
  - Other inputs are ignored.
- RUN: outputs are combinational from the inputs, with this priority:
  - ext_stall=1: all enables 0, id_ex_bubble 0, if_id_reset 0. Next state HOLD. If annul_req is also high, set annul_pending.
  - else load_use_hazard=1: pc_enable, npc_enable and if_id_enable = 0; id_ex_bubble=1; if_id_reset=0. Stay in RUN. annul_req is ignored this cycle because the branch stays in ID and is re-evaluated next cycle.
  - else: all enables 1, id_ex_bubble 0, if_id_reset = annul_req. Stay in RUN.
- HOLD:
  - All enables 0, bubble 0, if_id_reset 0. Stall counter increments, saturating at 255.
  - When the counter reaches STALL_TIMEOUT, stall_timeout sets and stays set until system_reset.
  - An annul_req while in HOLD also sets annul_pending.
  - When ext_stall drops: return to RUN, clear the stall counter, and on that first RUN cycle apply if_id_reset = annul_pending | annul_req. If no load_use_hazard is present, clear annul_pending.
  - If load_use_hazard is present on that first RUN cycle, annul_pending persists until the first advancing cycle.
- Annul is single-shot: if_id_reset is high for exactly one advancing cycle per branch.
- Latency: zero-cycle combinational response to hazards in RUN; registered state change on the next edge.

Optional Feature:
- Macro ANNUL_STATS_EN.
- Defined: annul_count increments by 1 on every cycle where if_id_reset=1. It saturates at 16'hFFFF and clears on system_reset.
- Undefined: annul_count is tied to 16'h0000 and no counter logic is synthesized. The port still exists.

Test Plan:
- Reset with RESET_HOLD_CYCLES=4: pulse system_reset for 1 cycle -> pipe_reset high for 4 cycles, ctrl_state 00, then 01 with all enables 1 on cycle 5.
- ID_branch_instr=1, a=1, taken=0, always=0 in RUN -> if_id_reset=1 for exactly 1 cycle, enables 1. Repeat with taken=1 -> if_id_reset=0. Repeat with always=1, taken=1 -> if_id_reset=1.
- load_use_hazard=1 for 1 cycle with an annulling branch in ID -> pc/npc/if_id enables 0, id_ex_bubble=1, if_id_reset=0. Next cycle with hazard clear -> if_id_reset=1.
- ext_stall=1 for 3 cycles while annul_req=1 on the first -> ctrl_state 10 for 3 cycles, all enables 0. On release -> if_id_reset=1 once, annul_pending cleared.
- ext_stall held 64 cycles (STALL_TIMEOUT=64) -> stall_timeout=1 and stays 1 after release. system_reset mid-HOLD -> state INIT, stall_timeout=0, no if_id_reset after exit.
- ANNUL_STATS_EN defined, 3 annulled branches -> annul_count=3. Macro undefined -> annul_count=0.
